// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with configurable width/depth (any DEPTH >= 2), occupancy count,
// programmable almost flags and overflow/underflow pulses. Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads.
module fifo_sync_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 29,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_accept;
    logic             rd_accept;

    // Flags decode only the registered count, so wr/rd never reach them combinationally.
    assign count        = count_q;
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (32'(count_q) >= AF_LEVEL);
    assign almost_empty = (32'(count_q) <= AE_LEVEL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions, pointer wrap and occupancy update.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        // A write into a full FIFO still fits when the same edge frees a slot.
        rd_accept   = rd && (count_q != '0);
        wr_accept   = wr && ((count_q != CNT_FULL) || rd_accept);
        overflow_d  = wr && !wr_accept;
        underflow_d = rd && !rd_accept;

        if (wr_accept) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        if (wr_accept && !rd_accept) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; reset only blocks the write on its edge.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    // Head word is presented directly; zero while empty.
    assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_out_q, data_out_d;

    // Registered read: holds through idle and rejected reads.
    always_comb begin
        data_out_d = data_out_q;
        if (rd_accept) begin
            data_out_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
`endif

endmodule
